hif_fir_mac: RTL and testbench



---
 rtl/hif_fir_pkg.sv | 15 +
 rtl/hif_fir_mult.sv | 10 +
 rtl/hif_fir_mac.sv | 119 +++++++++++
 tb/tb_hif_fir_mac.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hif_fir_pkg.sv
// Shared widths and FSM state type for the high-frequency FIR MAC.
package hif_fir_pkg;
  localparam int unsigned SmplW      = 16;
  localparam int unsigned CoeffW     = 16;
  localparam int unsigned ProdW      = 32;
  localparam int unsigned CoeffAddrW = 11;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StFlush,
    StDone,
    StWait
  } state_e;
endpackage

// File: rtl/hif_fir_mult.sv
// Combinational signed 16x16 multiplier, kept separate so it maps onto a DSP slice.
module hif_fir_mult
  import hif_fir_pkg::*;
(
  input  logic signed [SmplW-1:0]  a,
  input  logic signed [CoeffW-1:0] b,
  output logic signed [ProdW-1:0]  p
);
  assign p = a * b;
endmodule

// File: rtl/hif_fir_mac.sv
// Windowed FIR multiply-accumulate on the HF queue's sequencing interface.
// Define HIF_FIR_SAT_EN to saturate filt_out instead of truncating.
module hif_fir_mac
  import hif_fir_pkg::*;
#(
  parameter int unsigned N_TAPS = 1021,
  parameter int unsigned ACC_W  = 42,
  parameter int unsigned SHIFT  = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [SmplW-1:0]      smpl_in,
  input  logic                         sequencing,
  output logic        [CoeffAddrW-1:0] coeff_addr,
  input  logic signed [CoeffW-1:0]     coeff_in,
  output logic        [SmplW-1:0]      filt_out,
  output logic                         filt_vld,
  output logic                         win_err
);
  localparam logic [CoeffAddrW-1:0] LastCnt = CoeffAddrW'(N_TAPS - 1);

  state_e                  state;
  logic [CoeffAddrW-1:0]   cnt;
  logic signed [SmplW-1:0] smpl_d;
  logic signed [ProdW-1:0] prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic [SmplW-1:0]        filt_next;

  // Address leads the sample by one cycle so the ROM latency lines up with smpl_d.
  assign coeff_addr = cnt;

  hif_fir_mult u_mult (
    .a (smpl_d),
    .b (coeff_in),
    .p (prod)
  );

  assign prod_ext = {{(ACC_W - ProdW){prod[ProdW-1]}}, prod};

`ifdef HIF_FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SatMax = 32767;
  localparam logic signed [ACC_W-1:0] SatMin = -32768;
  logic signed [ACC_W-1:0] acc_sh;

  assign acc_sh = acc >>> SHIFT;

  always_comb begin
    filt_next = acc_sh[SmplW-1:0];
    if (acc_sh > SatMax) begin
      filt_next = 16'h7FFF;
    end else if (acc_sh < SatMin) begin
      filt_next = 16'h8000;
    end
  end
`else
  always_comb begin
    filt_next = acc[SHIFT+SmplW-1:SHIFT];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      cnt      <= '0;
      acc      <= '0;
      smpl_d   <= '0;
      filt_out <= '0;
      filt_vld <= 1'b0;
      win_err  <= 1'b0;
    end else begin
      smpl_d   <= smpl_in;
      filt_vld <= 1'b0;
      win_err  <= 1'b0;
      case (state)
        StIdle: begin
          acc <= '0;
          cnt <= '0;
          if (sequencing) begin
            cnt   <= CoeffAddrW'(1);
            state <= (N_TAPS == 1) ? StFlush : StAccum;
          end
        end
        StAccum: begin
          if (!sequencing) begin
            win_err <= 1'b1;
            acc     <= '0;
            cnt     <= '0;
            state   <= StIdle;
          end else begin
            acc <= acc + prod_ext;
            cnt <= cnt + 1'b1;
            if (cnt == LastCnt) begin
              state <= StFlush;
            end
          end
        end
        StFlush: begin
          acc   <= acc + prod_ext;
          state <= StDone;
        end
        StDone: begin
          filt_out <= filt_next;
          filt_vld <= 1'b1;
          state    <= StWait;
        end
        StWait: begin
          // A window only restarts after sequencing has been seen low.
          if (!sequencing) begin
            acc   <= '0;
            cnt   <= '0;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_hif_fir_mac.sv
// Scoreboard bench for hif_fir_mac: driver pushes expected pulses, monitor pops and checks.
module tb_hif_fir_mac;
  localparam int N_TAPS = 1021;
  localparam int ACC_W  = 42;
  localparam int SHIFT  = 15;

  typedef struct {
    bit          is_err;
    logic [15:0] val;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] smpl_in;
  logic        sequencing;
  logic [10:0] coeff_addr;
  logic [15:0] coeff_in;
  logic [15:0] filt_out;
  logic        filt_vld;
  logic        win_err;

  logic [15:0] rom [0:2047];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  hif_fir_mac #(
    .N_TAPS (N_TAPS),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .smpl_in    (smpl_in),
    .sequencing (sequencing),
    .coeff_addr (coeff_addr),
    .coeff_in   (coeff_in),
    .filt_out   (filt_out),
    .filt_vld   (filt_vld),
    .win_err    (win_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous coefficient ROM: data one clock after the address.
  always @(posedge clk) coeff_in <= rom[coeff_addr];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
               nm, act, act, req, req, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (filt_vld || win_err)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: vld=%0b err=%0b with nothing expected at cyc %0d",
                 filt_vld, win_err, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind_err", longint'(win_err), longint'(e.is_err));
        chk("pulse_kind_vld", longint'(filt_vld), longint'(!e.is_err));
        chk("pulse_cycle", longint'(cyc), longint'(e.cyc));
        if (!e.is_err) chk("filt_out", longint'(filt_out), longint'(e.val));
      end
    end
  end

  function automatic logic [15:0] gen_smpl(input int mode, input int idx);
    case (mode)
      1:       return 16'h4000;
      2:       return (idx == 100) ? 16'h7FFF : 16'h0000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Ideal windowed dot product, then scale to the 16-bit output format.
  function automatic logic [15:0] model_out(input logic [15:0] s [N_TAPS]);
    longint acc;
    longint sh;
    acc = 0;
    for (int i = 0; i < N_TAPS; i++) begin
      acc += longint'($signed(s[i])) * longint'($signed(rom[i]));
    end
    sh = acc >>> SHIFT;
`ifdef HIF_FIR_SAT_EN
    if (sh > 32767) return 16'h7FFF;
    if (sh < -32768) return 16'h8000;
`endif
    return sh[15:0];
  endfunction

  // Called at a negedge. abort_at > 0 pulls reset after that many samples.
  task automatic drive_window(input int mode, input int n_high, input int abort_at);
    logic [15:0] s [N_TAPS];
    exp_t        e;
    int          c0;
    for (int i = 0; i < N_TAPS; i++) s[i] = gen_smpl(mode, i);
    c0 = cyc;
    if (abort_at == 0) begin
      if (n_high >= N_TAPS) begin
        e.is_err = 1'b0;
        e.val    = model_out(s);
        e.cyc    = c0 + N_TAPS + 2;
      end else begin
        e.is_err = 1'b1;
        e.val    = 16'h0;
        e.cyc    = c0 + n_high + 1;
      end
      exp_q.push_back(e);
    end
    for (int i = 0; i < n_high; i++) begin
      if (abort_at != 0 && i == abort_at) begin
        rst_n      = 1'b0;
        sequencing = 1'b0;
        #1;
        chk("rst_filt_out", longint'(filt_out), 0);
        chk("rst_filt_vld", longint'(filt_vld), 0);
        chk("rst_win_err", longint'(win_err), 0);
        chk("rst_coeff_addr", longint'(coeff_addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      smpl_in    = (i < N_TAPS) ? s[i] : 16'($urandom);
      sequencing = 1'b1;
      @(negedge clk);
    end
    sequencing = 1'b0;
    smpl_in    = 16'($urandom);
    repeat ($urandom_range(3, 8)) @(negedge clk);
  endtask

  task automatic load_rom(input int mode);
    for (int i = 0; i < 2048; i++) begin
      case (mode)
        1:       rom[i] = 16'h0001;
        2:       rom[i] = 16'(i);
        3:       rom[i] = 16'h7FFF;
        default: rom[i] = 16'($urandom);
      endcase
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    sequencing = 1'b0;
    smpl_in    = 16'h0;
    load_rom(1);
    repeat (3) @(negedge clk);
    chk("reset_filt_out", longint'(filt_out), 0);
    chk("reset_filt_vld", longint'(filt_vld), 0);
    chk("reset_win_err", longint'(win_err), 0);
    chk("reset_coeff_addr", longint'(coeff_addr), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Constant: 1021*16384 >> 15 = 510.
    drive_window(1, N_TAPS, 0);
    // Impulse at index 100 against coeff[k]=k: 100*32767 >> 15 = 99.
    load_rom(2);
    @(negedge clk);
    drive_window(2, N_TAPS, 0);
    // Full-scale overflow.
    load_rom(3);
    @(negedge clk);
    drive_window(3, N_TAPS, 0);
    // Early drop after 500 samples, then a clean window.
    load_rom(0);
    @(negedge clk);
    drive_window(0, 500, 0);
    drive_window(0, N_TAPS, 0);
    // Sequencing held beyond the window: one pulse only.
    drive_window(0, 1100, 0);
    // Reset in the middle of a window, then a clean window.
    drive_window(0, N_TAPS, 600);
    repeat (2) @(negedge clk);
    drive_window(0, N_TAPS, 0);
    // A few random windows, some short.
    for (int k = 0; k < 4; k++) begin
      load_rom(0);
      @(negedge clk);
      if ($urandom_range(0, 3) == 0)
        drive_window(0, $urandom_range(1, N_TAPS - 1), 0);
      else
        drive_window(0, N_TAPS + $urandom_range(0, 20), 0);
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", longint'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
